// File: rtl/imu_i2c_sched.sv
`default_nettype none
// ============================================================================
// Module   : imu_i2c_sched
// Purpose  : Arbitrates IMU burst reads (interrupt driven) and config writes
//            onto a single I2C master command port, with timeout abort and
//            a saturating count of dropped data-ready interrupts.
// Revision : 1.0  initial release
// ============================================================================
module imu_i2c_sched #(
    parameter logic [6:0] IMU_ADDR  = 7'h68,
    parameter logic [7:0] DATA_REG  = 8'h3B,
    parameter int         BURST_LEN = 14,
    parameter int         TIMEOUT   = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_icu_int,
    input  logic       i_cfg_req,
    input  logic [7:0] i_cfg_reg,
    input  logic [7:0] i_cfg_data,
    output logic       o_cfg_ack,
    output logic       o_cmd_valid,
    input  logic       i_cmd_ready,
    output logic       o_cmd_rw,
    output logic [6:0] o_cmd_dev,
    output logic [7:0] o_cmd_reg,
    output logic [3:0] o_cmd_len,
    output logic [7:0] o_cmd_wdata,
    input  logic       i_i2c_busy,
    output logic       o_i2c_read_en,
    output logic       o_err,
    output logic [7:0] o_drop_cnt
);

    localparam int            c_TW       = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_int_s1, r_int_s2, r_int_s3;
    logic            r_read_pend;
    logic            r_last_rd;     // 1: last grant was a read, 0: config
    logic            r_gnt_rd;      // type of the transfer currently owned
    logic            r_busy_q;
    logic [c_TW-1:0] r_tmo;
    logic [7:0]      r_drop;
    logic            r_cfg_ack, r_cmd_valid, r_cmd_rw, r_read_en, r_err;
    logic [7:0]      r_cmd_reg, r_cmd_wdata;
    logic [3:0]      r_cmd_len;

    logic w_edge, w_rd_grant, w_cfg_grant, w_rd_busy, w_busy_fall;

    // On a tie the requester type that was not served last wins.
    assign w_edge      = r_int_s2 & ~r_int_s3;
    assign w_rd_grant  = (r_state == S_IDLE) && r_read_pend && (!i_cfg_req || !r_last_rd);
    assign w_cfg_grant = (r_state == S_IDLE) && i_cfg_req && (!r_read_pend || r_last_rd);
    assign w_rd_busy   = (r_state != S_IDLE) && r_gnt_rd;
    assign w_busy_fall = r_busy_q & ~i_i2c_busy;

    // Interrupt synchroniser, pending-read flag and dropped-interrupt counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_s1    <= 1'b0;
            r_int_s2    <= 1'b0;
            r_int_s3    <= 1'b0;
            r_read_pend <= 1'b0;
            r_drop      <= 8'd0;
        end else begin
            r_int_s1 <= i_icu_int;
            r_int_s2 <= r_int_s1;
            r_int_s3 <= r_int_s2;
            // An edge arriving while a read is pending, owned or being
            // granted this very cycle carries no new information: drop it.
            if (w_rd_grant)
                r_read_pend <= 1'b0;
            else if (w_edge && !w_rd_busy)
                r_read_pend <= 1'b1;
            if (w_edge && (r_read_pend || w_rd_busy || w_rd_grant) && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

    // Transfer FSM with registered command and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_rd   <= 1'b0;
            r_gnt_rd    <= 1'b0;
            r_busy_q    <= 1'b0;
            r_tmo       <= '0;
            r_cfg_ack   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_rw    <= 1'b0;
            r_cmd_reg   <= 8'd0;
            r_cmd_len   <= 4'd0;
            r_cmd_wdata <= 8'd0;
            r_read_en   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cfg_ack <= 1'b0;
            r_err     <= 1'b0;
            r_busy_q  <= i_i2c_busy;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_grant) begin
                        r_gnt_rd    <= 1'b1;
                        r_last_rd   <= 1'b1;
                        r_cmd_rw    <= 1'b1;
                        r_cmd_reg   <= DATA_REG;
                        r_cmd_len   <= 4'(BURST_LEN);
                        r_cmd_wdata <= 8'd0;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else if (w_cfg_grant) begin
                        r_gnt_rd    <= 1'b0;
                        r_last_rd   <= 1'b0;
                        r_cmd_rw    <= 1'b0;
                        r_cmd_reg   <= i_cfg_reg;
                        r_cmd_len   <= 4'd1;
                        r_cmd_wdata <= i_cfg_data;
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (i_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_read_en   <= r_gnt_rd;
                        r_tmo       <= '0;
                        r_state     <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (r_tmo == c_TMO_LAST) begin
                        r_state   <= S_IDLE;
                        r_err     <= 1'b1;
                        r_read_en <= 1'b0;
                        r_cfg_ack <= ~r_gnt_rd;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                        if (i_i2c_busy)
                            r_state <= S_WAIT_DONE;
                    end
                end
                default: begin
                    // Completion takes precedence over a coincident timeout.
                    if (w_busy_fall) begin
                        r_state   <= S_IDLE;
                        r_read_en <= 1'b0;
                        r_cfg_ack <= ~r_gnt_rd;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_state   <= S_IDLE;
                        r_err     <= 1'b1;
                        r_read_en <= 1'b0;
                        r_cfg_ack <= ~r_gnt_rd;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_cfg_ack     = r_cfg_ack;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_cmd_rw      = r_cmd_rw;
    assign o_cmd_dev     = IMU_ADDR;
    assign o_cmd_reg     = r_cmd_reg;
    assign o_cmd_len     = r_cmd_len;
    assign o_cmd_wdata   = r_cmd_wdata;
    assign o_i2c_read_en = r_read_en;
    assign o_err         = r_err;
    assign o_drop_cnt    = r_drop;

endmodule
`default_nettype wire

// File: doc/imu_i2c_sched.md
IMU_I2C_SCHED -- requirements
Module: imu_i2c_sched

Interface
REQ-001 SHALL provide parameter IMU_ADDR, 7'h68, 7-bit I2C device address used for all commands.
REQ-002 SHALL provide parameter DATA_REG, 8'h3B, first register of the sensor burst read.
REQ-003 SHALL provide parameter BURST_LEN, 14, byte count of the sensor burst read (1..15).
REQ-004 SHALL provide parameter TIMEOUT, 4095, maximum cycles in WAIT_START plus WAIT_DONE before abort.
REQ-005 CLK  in  1  single clock, all logic on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 ICU_INT  in  1  IMU data-ready interrupt, asynchronous to CLK.
REQ-008 CFG_REQ  in  1  config-write request, held until CFG_ACK.
REQ-009 CFG_REG  in  8  config register address, stable while CFG_REQ=1.
REQ-010 CFG_DATA  in  8  config write byte, stable while CFG_REQ=1.
REQ-011 CFG_ACK  out  1  one-cycle pulse when the config write completes or aborts.
REQ-012 CMD_VALID  out  1  command valid to I2C master.
REQ-013 CMD_READY  in  1  I2C master accepts command when CMD_VALID=CMD_READY=1.
REQ-014 CMD_RW  out  1  1=read, 0=write.
REQ-015 CMD_DEV  out  7  device address (=IMU_ADDR).
REQ-016 CMD_REG  out  8  register address.
REQ-017 CMD_LEN  out  4  byte count (read: BURST_LEN, write: 1).
REQ-018 CMD_WDATA  out  8  write byte (CFG_DATA latched; 0 for reads).
REQ-019 I2C_BUSY  in  1  high while I2C master executes a transfer.
REQ-020 I2C_READ_EN  out  1  high from read command accept until read transfer ends; qualifies collector bytes.
REQ-021 ERR  out  1  one-cycle pulse on timeout abort.
REQ-022 DROP_CNT  out  8  count of dropped interrupts, saturating at 255.

Function
REQ-023 SHALL synchronise ICU_INT through two flops and detect rising edge on a third; edge sets READ_PEND.
REQ-024 SHALL, on an edge while READ_PEND=1 or a read is in progress, leave READ_PEND unchanged and increment DROP_CNT (hold at 255).
REQ-025 SHALL implement states IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-026 IDLE: if READ_PEND or CFG_REQ, grant and go ISSUE next cycle; latch command fields at grant.
REQ-027 Arbitration: single requester wins; both pending -> grant the type not granted last (LAST_GNT flop, reset = config, so read wins first tie).
REQ-028 Read grant SHALL clear READ_PEND at grant cycle; an edge on that same cycle is counted as dropped.
REQ-029 ISSUE: CMD_VALID=1 with fields stable; on CMD_READY go WAIT_START; read grant sets I2C_READ_EN same edge.
REQ-030 WAIT_START: on I2C_BUSY=1 go WAIT_DONE.
REQ-031 WAIT_DONE: on I2C_BUSY falling (registered 1 -> 0) go IDLE, clear I2C_READ_EN, pulse CFG_ACK if config grant.
REQ-032 Timeout counter SHALL clear on entry to WAIT_START and increment each cycle in WAIT_START/WAIT_DONE; reaching TIMEOUT -> IDLE, ERR pulse, I2C_READ_EN=0, CFG_ACK pulse if config grant.
REQ-033 ISSUE has no timeout; CMD_VALID held until accepted.
REQ-034 Minimum gap between transfers SHALL be one IDLE cycle.
REQ-035 CMD_* SHALL hold last values outside ISSUE; only CMD_VALID qualifies.
REQ-036 CFG_REQ deassertion before grant SHALL cancel that request with no ACK.

Reset
REQ-037 SHALL, with RST_N=0, force state IDLE, CMD_VALID=0, CMD_RW=0, CMD_DEV=IMU_ADDR, CMD_REG=0, CMD_LEN=0, CMD_WDATA=0, CFG_ACK=0, I2C_READ_EN=0, ERR=0, DROP_CNT=0, READ_PEND=0, LAST_GNT=config, sync flops 0, timeout counter 0.
REQ-038 Reset asserted mid-transfer SHALL abort immediately with no ACK or ERR pulse after release.

Verification
REQ-039 ICU_INT rise, CMD_READY=1, BUSY high 20 cycles -> CMD_RW=1, CMD_REG=8'h3B, CMD_LEN=14, I2C_READ_EN high from accept to BUSY fall, back to IDLE.
REQ-040 CFG_REQ with REG=8'h6B, DATA=8'h00 -> write command LEN=1, WDATA=0; CFG_ACK one pulse after BUSY fall.
REQ-041 ICU_INT edge and CFG_REQ same cycle after reset -> read first, then config; repeat tie -> config first.
REQ-042 300 ICU_INT edges during one stalled transfer -> DROP_CNT=255, exactly one read issued afterward.
REQ-043 BUSY never rises after accept -> ERR pulse after TIMEOUT cycles, I2C_READ_EN=0, IDLE.
REQ-044 RST_N low during WAIT_DONE -> all outputs at reset values, no CFG_ACK or ERR after release.
